eth_tx_sched: RTL and testbench

- Controller in front of the 10BASE-T transmitter inside the sender design.
- Shares the single Ethernet MAC/serializer between two frame requesters: the audio PDM packetizer and a control/announce frame source.
- Enforces the inter-frame gap and generates 10BASE-T normal link pulses (NLP) while the line is idle.
- All timing is counted in eth_clk_stb strobes (one per 100 ns bit time); everything runs on clk.

---
 rtl/eth_pkg.sv | 27 ++
 rtl/eth_tx_arb.sv | 58 +++++
 rtl/eth_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_eth_tx_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and default timing constants for the 10BASE-T tx scheduler.
// Holds the FSM state enum, MAC source select codes and bit-time defaults.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    BUSY,
    IFG,
    NLP
  } state_e;

  localparam logic SRC_AUD = 1'b0;
  localparam logic SRC_CTL = 1'b1;

  localparam int IFG_BITS   = 96;
  localparam int NLP_PERIOD = 160000;
  localparam int NLP_WIDTH  = 1;
  localparam int START_TMO  = 8;

  // Counter width able to hold 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eth_tx_arb.sv
// 2-way arbiter between audio and control frame sources.
// Ports: clk, rst, aud_req_i, ctl_req_i, upd_i (commit grant) -> any_o, sel_o.
// ETH_TX_SCHED_AUD_PRIO_EN selects strict audio priority instead of round-robin.
module eth_tx_arb
  import eth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic aud_req_i,
  input  logic ctl_req_i,
  input  logic upd_i,
  output logic any_o,
  output logic sel_o
);

  assign any_o = aud_req_i | ctl_req_i;

`ifdef ETH_TX_SCHED_AUD_PRIO_EN

  // Audio always wins; no pointer state is kept.
  assign sel_o = aud_req_i ? SRC_AUD : SRC_CTL;

  logic unused_prio;
  assign unused_prio = &{1'b0, clk, rst, upd_i};

`else

  // prio_q names the source that wins the next tie.
  logic prio_q;
  logic prio_d;

  always_comb begin
    sel_o = SRC_AUD;
    if (aud_req_i && ctl_req_i) begin
      sel_o = prio_q;
    end else if (ctl_req_i) begin
      sel_o = SRC_CTL;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (upd_i) begin
      prio_d = ~sel_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= SRC_AUD;
    end else begin
      prio_q <= prio_d;
    end
  end

`endif

endmodule

// File: rtl/eth_tx_sched.sv
// Shares one 10BASE-T MAC between audio and control sources; enforces the
// inter-frame gap and emits normal link pulses while the line is idle.
// Ports: clk, rst, eth_clk_stb, aud_req, ctl_req, mac_busy in;
//        aud_gnt, ctl_gnt, mac_start, mac_src, nlp_out, err_tmo out.
// Macro ETH_TX_SCHED_AUD_PRIO_EN: strict audio priority in the arbiter.
module eth_tx_sched #(
  parameter int IFG_BITS   = 96,
  parameter int NLP_PERIOD = 160000,
  parameter int NLP_WIDTH  = 1,
  parameter int START_TMO  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic eth_clk_stb,
  input  logic aud_req,
  input  logic ctl_req,
  output logic aud_gnt,
  output logic ctl_gnt,
  output logic mac_start,
  output logic mac_src,
  input  logic mac_busy,
  output logic nlp_out,
  output logic err_tmo
);

  import eth_pkg::*;

  localparam int IW = cnt_w(NLP_PERIOD);
  localparam int GW = cnt_w(IFG_BITS);
  localparam int LW = cnt_w(NLP_WIDTH);
  localparam int TW = cnt_w(START_TMO + 1);

  localparam logic [IW-1:0] IDLE_LAST = IW'(NLP_PERIOD - 1);
  localparam logic [GW-1:0] IFG_LAST  = GW'(IFG_BITS - 1);
  localparam logic [LW-1:0] NLP_LAST  = LW'(NLP_WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(START_TMO - 1);

  state_e        state_q;
  logic [IW-1:0] idle_cnt_q;
  logic [GW-1:0] ifg_cnt_q;
  logic [LW-1:0] nlp_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          aud_gnt_q;
  logic          ctl_gnt_q;
  logic          mac_start_q;
  logic          mac_src_q;
  logic          nlp_q;
  logic          err_q;

  logic arb_any;
  logic arb_sel;
  logic arb_upd;

  assign arb_upd = (state_q == IDLE) && arb_any;

  eth_tx_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .aud_req_i (aud_req),
    .ctl_req_i (ctl_req),
    .upd_i     (arb_upd),
    .any_o     (arb_any),
    .sel_o     (arb_sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idle_cnt_q  <= '0;
      ifg_cnt_q   <= '0;
      nlp_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      aud_gnt_q   <= 1'b0;
      ctl_gnt_q   <= 1'b0;
      mac_start_q <= 1'b0;
      mac_src_q   <= 1'b0;
      nlp_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mac_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A pending request beats a link-timer expiry on the same clk.
          if (arb_any) begin
            state_q     <= START;
            mac_start_q <= 1'b1;
            aud_gnt_q   <= (arb_sel == SRC_AUD);
            ctl_gnt_q   <= (arb_sel == SRC_CTL);
            mac_src_q   <= arb_sel;
            idle_cnt_q  <= '0;
          end else if (eth_clk_stb) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_q    <= NLP;
              idle_cnt_q <= '0;
              nlp_q      <= 1'b1;
              nlp_cnt_q  <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        START: begin
          // The START clk counts toward the busy-rise timeout.
          state_q   <= WAIT;
          tmo_cnt_q <= TW'(1);
        end
        WAIT: begin
          if (mac_busy) begin
            state_q <= BUSY;
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q   <= IFG;
            err_q     <= 1'b1;
            aud_gnt_q <= 1'b0;
            ctl_gnt_q <= 1'b0;
            mac_src_q <= 1'b0;
            ifg_cnt_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        BUSY: begin
          if (!mac_busy) begin
            state_q   <= IFG;
            aud_gnt_q <= 1'b0;
            ctl_gnt_q <= 1'b0;
            mac_src_q <= 1'b0;
            ifg_cnt_q <= '0;
          end
        end
        IFG: begin
          if (eth_clk_stb) begin
            if (ifg_cnt_q == IFG_LAST) begin
              state_q   <= IDLE;
              ifg_cnt_q <= '0;
            end else begin
              ifg_cnt_q <= ifg_cnt_q + 1'b1;
            end
          end
        end
        NLP: begin
          if (eth_clk_stb) begin
            if (nlp_cnt_q == NLP_LAST) begin
              state_q   <= IFG;
              nlp_q     <= 1'b0;
              nlp_cnt_q <= '0;
              ifg_cnt_q <= '0;
            end else begin
              nlp_cnt_q <= nlp_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign aud_gnt   = aud_gnt_q;
  assign ctl_gnt   = ctl_gnt_q;
  assign mac_start = mac_start_q;
  assign mac_src   = mac_src_q;
  assign nlp_out   = nlp_q;
  assign err_tmo   = err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched with NLP_PERIOD=1000, strobe every 2nd clk.
// Covers reset, latency, IFG, arbitration, link pulses, timeout, async reset.
module tb_eth_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eth_clk_stb = 1'b0;
  logic aud_req = 1'b0;
  logic ctl_req = 1'b0;
  logic mac_busy = 1'b0;
  logic aud_gnt;
  logic ctl_gnt;
  logic mac_start;
  logic mac_src;
  logic nlp_out;
  logic err_tmo;

  int n_chk = 0;
  int n_err = 0;

  eth_tx_sched #(
    .NLP_PERIOD (1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .eth_clk_stb (eth_clk_stb),
    .aud_req     (aud_req),
    .ctl_req     (ctl_req),
    .aud_gnt     (aud_gnt),
    .ctl_gnt     (ctl_gnt),
    .mac_start   (mac_start),
    .mac_src     (mac_src),
    .mac_busy    (mac_busy),
    .nlp_out     (nlp_out),
    .err_tmo     (err_tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) eth_clk_stb = ~eth_clk_stb;

  int cyc = 0;
  int stb_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) stb_cnt <= 0;
    else if (eth_clk_stb) stb_cnt <= stb_cnt + 1;
  end

  bit mac_en = 1'b1;
  int flen = 20;
  int mcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      mac_busy = 1'b0;
      mcnt = 0;
    end else if (mac_start && mac_en) begin
      mac_busy = 1'b1;
      mcnt = flen;
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) mac_busy = 1'b0;
    end
  end

  logic st_src[$];
  int oh_viol = 0;
  always @(negedge clk) begin
    if (mac_start) st_src.push_back(mac_src);
    if (aud_gnt && ctl_gnt) oh_viol <= oh_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    aud_req = 1'b0;
    ctl_req = 1'b0;
    mac_en = 1'b1;
    flen = 20;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    st_src.delete();
    #1;
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n0;
    bit seen;
    n0 = st_src.size();
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (st_src.size() > n0) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  task automatic wait_nlp(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (nlp_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, 32'(seen), 1);
  endtask

  logic exp_src [3];
  int   t0;
  int   t1;
  int   w;
  bit   ok;

  initial begin
`ifdef ETH_TX_SCHED_AUD_PRIO_EN
    exp_src = '{1'b0, 1'b0, 1'b0};
`else
    exp_src = '{1'b0, 1'b1, 1'b0};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_aud_gnt", 32'(aud_gnt), 0);
    chk("rst_ctl_gnt", 32'(ctl_gnt), 0);
    chk("rst_start", 32'(mac_start), 0);
    chk("rst_src", 32'(mac_src), 0);
    chk("rst_nlp", 32'(nlp_out), 0);
    chk("rst_err", 32'(err_tmo), 0);

    // Single audio request: 1 clk latency, grant held through busy
    do_reset();
    aud_req = 1'b1;
    tick();
    chk("one_start", 32'(mac_start), 1);
    chk("one_src", 32'(mac_src), 0);
    chk("one_aud_gnt", 32'(aud_gnt), 1);
    chk("one_ctl_gnt", 32'(ctl_gnt), 0);
    aud_req = 1'b0;
    tick();
    chk("one_pulse", 32'(mac_start), 0);
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!aud_gnt) ok = 1'b0;
      tick();
      if (!mac_busy) break;
    end
    chk("one_gnt_held", 32'(ok), 1);
    @(posedge clk);
    #1;
    chk("one_gnt_drop", 32'(aud_gnt), 0);
    t0 = cyc;
    aud_req = 1'b1;
    wait_start(500, "one_restart_seen");
    t1 = cyc;
    aud_req = 1'b0;
    chk("one_ifg_gap", 32'(t1 - t0 >= 192), 1);

    // Contention over three frames
    do_reset();
    aud_req = 1'b1;
    ctl_req = 1'b1;
    for (int f = 0; f < 3; f++) wait_start(600, "arb_seen");
    aud_req = 1'b0;
    ctl_req = 1'b0;
    for (int f = 0; f < 3; f++) begin
      chk($sformatf("arb_src%0d", f), 32'(st_src[f]), 32'(exp_src[f]));
    end

    // Idle line link pulses
    do_reset();
    wait_nlp(3000, "nlp_first_seen");
    t0 = cyc;
    chk("nlp_first_stb", 32'(stb_cnt), 1000);
    w = 0;
    while (nlp_out && w < 10) begin
      w++;
      tick();
    end
    chk("nlp_width", 32'(w), 2);
    wait_nlp(3000, "nlp_second_seen");
    chk("nlp_period", 32'(cyc - t0), 2194);
    chk("nlp_no_start", 32'(st_src.size()), 0);

    // Request on the same clk as link-timer expiry
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (stb_cnt == 999 && eth_clk_stb) break;
    end
    aud_req = 1'b1;
    tick();
    chk("coll_start", 32'(mac_start), 1);
    chk("coll_nlp", 32'(nlp_out), 0);
    aud_req = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (nlp_out) ok = 1'b0;
      if (!aud_gnt) break;
    end
    chk("coll_no_nlp", 32'(ok), 1);
    t0 = stb_cnt;
    wait_nlp(3000, "coll_nlp_seen");
    chk("coll_restart", 32'(stb_cnt - t0), 1096);

    // mac_busy never rises: timeout, then next request served
    do_reset();
    mac_en = 1'b0;
    aud_req = 1'b1;
    wait_start(10, "tmo_start_seen");
    t0 = cyc;
    aud_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (err_tmo) break;
      tick();
    end
    chk("tmo_delay", 32'(cyc - t0), 8);
    chk("tmo_err", 32'(err_tmo), 1);
    chk("tmo_gnt_drop", 32'(aud_gnt), 0);
    mac_en = 1'b1;
    flen = 300;
    ctl_req = 1'b1;
    wait_start(400, "tmo_next_seen");
    ctl_req = 1'b0;
    chk("tmo_next_src", 32'(mac_src), 1);
    repeat (4) tick();
    chk("tmo_next_gnt", 32'(ctl_gnt), 1);
    chk("tmo_sticky", 32'(err_tmo), 1);

    // Asynchronous reset in the middle of a frame
    chk("busy_mid", 32'(mac_busy), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_aud_gnt", 32'(aud_gnt), 0);
    chk("arst_ctl_gnt", 32'(ctl_gnt), 0);
    chk("arst_src", 32'(mac_src), 0);
    chk("arst_start", 32'(mac_start), 0);
    chk("arst_nlp", 32'(nlp_out), 0);
    chk("arst_err", 32'(err_tmo), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tick();
    chk("post_err", 32'(err_tmo), 0);
    aud_req = 1'b1;
    tick();
    chk("post_start", 32'(mac_start), 1);
    chk("post_src", 32'(mac_src), 0);
    aud_req = 1'b0;
    repeat (5) tick();

    chk("onehot", 32'(oh_viol), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
